// File: rtl/shift_issue_stage.sv
// ---------------------------------------------------------------------------
// shift_issue_stage : two-stage pipelined shift/rotate unit with handshakes
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_issue_stage_ror #(
   parameter int W = 8
) (
   input  logic [W-1:0] data_in,
   input  logic [3:0]   amt,
   output logic [W-1:0] data_out
);
   logic [W-1:0] stage [0:4];

   assign stage[0] = data_in;

   // Log rotator: stage k rotates right by 2**k (mod W) when amt[k] is set.
   for (genvar k = 0; k < 4; k++) begin : g_stage
      localparam int SH = (2 ** k) % W;
      assign stage[k+1] = amt[k] ? W'({stage[k], stage[k]} >> SH) : stage[k];
   end

   assign data_out = stage[4];
endmodule

module shift_issue_stage #(
   parameter int DATA_W = 8,
   parameter int AMT_W  = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [1:0]        OPCODE,
   input  logic [DATA_W-1:0] INDATA,
   input  logic [AMT_W-1:0]  AMOUNT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] OUTDATA,
   output logic              OUT_ZERO
);
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic [1:0]        op1_q, op1_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic [3:0]        eff1_q, eff1_d;
   logic              sat1_q, sat1_d;
   logic [DATA_W-1:0] res2_q, res2_d;
   logic              zero2_q, zero2_d;

   logic              adv2;
   logic              in_rdy;
   logic              in_fire;
   logic              cap_sat;
   logic [DATA_W-1:0] ror_res;
   logic [DATA_W-1:0] exec_res;

   always_comb begin
      adv2    = v1_q & (~v2_q | OUT_READY);
      in_rdy  = ~v1_q | adv2;
      in_fire = IN_VALID & in_rdy;
   end

   // Stage 1: capture operands, pre-decode amount into eff/sat.
   always_comb begin
      cap_sat = (OPCODE != OP_ROR) & (|AMOUNT[AMT_W-1:3]);
      v1_d    = in_fire | (v1_q & ~adv2);
      op1_d   = op1_q;
      data1_d = data1_q;
      eff1_d  = eff1_q;
      sat1_d  = sat1_q;
      if (in_fire) begin
         op1_d   = OPCODE;
         data1_d = INDATA;
         sat1_d  = cap_sat;
         eff1_d  = cap_sat ? 4'd0 : {1'b0, AMOUNT[2:0]};
      end
   end

   shift_issue_stage_ror #(
      .W (DATA_W)
   ) u_ror (
      .data_in  (data1_q),
      .amt      (eff1_q),
      .data_out (ror_res)
   );

   // Stage 2: execute and register result.
   always_comb begin
      exec_res = data1_q;
      case (op1_q)
         OP_SLL:  exec_res = sat1_q ? '0 : (data1_q << eff1_q);
         OP_SRL:  exec_res = sat1_q ? '0 : (data1_q >> eff1_q);
         OP_SRA:  exec_res = sat1_q ? {DATA_W{data1_q[DATA_W-1]}}
                                    : $unsigned($signed(data1_q) >>> eff1_q);
         default: exec_res = ror_res;
      endcase
      v2_d    = adv2 | (v2_q & ~OUT_READY);
      res2_d  = adv2 ? exec_res : res2_q;
      zero2_d = adv2 ? (exec_res == '0) : zero2_q;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         op1_q   <= 2'b00;
         data1_q <= '0;
         eff1_q  <= 4'd0;
         sat1_q  <= 1'b0;
         res2_q  <= '0;
         zero2_q <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         op1_q   <= op1_d;
         data1_q <= data1_d;
         eff1_q  <= eff1_d;
         sat1_q  <= sat1_d;
         res2_q  <= res2_d;
         zero2_q <= zero2_d;
      end
   end

   assign IN_READY  = in_rdy;
   assign OUT_VALID = v2_q;
   assign OUTDATA   = res2_q;
   assign OUT_ZERO  = zero2_q;
endmodule

`default_nettype wire

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Pipelined shift/rotate execution stage for the 8-bit processor datapath.
- Accepts an operand, a shift amount and a shift opcode from decode through a valid/ready handshake.
- Executes one of four shift/rotate operations and presents a registered result with a zero flag to writeback.
- Two register stages, full throughput, and backpressure support.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported.
- AMT_W, 8, width of the AMOUNT field (instruction immediate byte).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset; clears all state immediately when low.
- IN_VALID  in  1  upstream holds a valid operation.
- IN_READY  out  1  stage can accept this cycle.
- OPCODE  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- INDATA  in  8  operand.
- AMOUNT  in  8  shift amount (unsigned).
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts the result.
- OUTDATA  out  8  result.
- OUT_ZERO  out  1  high when OUTDATA == 0 (qualified by OUT_VALID).

Behaviour:
- Reset (RESET low, asynchronous):
  - v1, v2 = 0; OUT_VALID = 0; OUTDATA = 0x00; OUT_ZERO = 0; stage registers = 0.
  - Deassertion takes effect at the next CLK edge.
  - Any in-flight operations are discarded when reset asserts mid-operation.
- Stage 1 (capture):
  - Transfer occurs when IN_VALID & IN_READY.
  - Registers OPCODE and INDATA plus a precomputed effective amount (4 bits) and a saturate flag.
  - ROR: eff = AMOUNT[2:0], sat = 0 (amount mod 8).
  - SLL/SRL/SRA: sat = (AMOUNT >= 8); eff = AMOUNT[2:0] when sat is 0.
- Stage 2 (execute):
  - Result computed from stage-1 registers and registered into OUTDATA/OUT_ZERO.
  - SLL: INDATA << eff; sat -> 0x00.
  - SRL: INDATA >> eff, zero fill; sat -> 0x00.
  - SRA: sign-filled right shift; sat -> 0xFF if INDATA[7]=1, else 0x00.
  - ROR: right rotate by eff, using the existing mux-based rotate-right unit (4-bit amount, bit 3 tied 0).
  - Amount 0 in any opcode: result = INDATA.
- Handshake:
  - adv2 = v1 & (!v2 | OUT_READY).
  - IN_READY = !v1 | adv2 (combinational from OUT_READY; no combinational path from IN_VALID).
  - OUT_VALID = v2; v2 clears on OUT_READY unless adv2 refills it the same cycle.
  - Latency: 2 cycles from accept to OUT_VALID when unstalled; throughput 1 op/cycle.
  - While OUT_VALID & !OUT_READY, OUTDATA/OUT_ZERO hold stable and stage 1 holds its contents.
  - With both stages full and OUT_READY low, IN_READY = 0.
  - Simultaneous accept, advance and drain in one cycle must lose or duplicate no operation.
- Upstream must hold OPCODE/INDATA/AMOUNT stable while IN_VALID & !IN_READY; no internal buffering beyond the two stages.

Test Plan:
- Reset: RESET low mid-stream with both stages full -> OUT_VALID=0, OUTDATA=0x00 immediately; after release, first accepted op appears 2 cycles later.
- ROR: 0xB4 by 3 -> 0x96, OUT_ZERO=0. ROR 0xB4 by 8 -> 0xB4. ROR 0xB4 by 11 -> 0x96.
- Shifts:
  - SLL 0x81 by 1 -> 0x02.
  - SRL 0x81 by 8 -> 0x00, OUT_ZERO=1.
  - SRA 0x90 by 2 -> 0xE4.
  - SRA 0x90 by 9 -> 0xFF.
  - SRA 0x70 by 200 -> 0x00.
- Back-to-back: 4 consecutive ops with OUT_READY=1 -> IN_READY stays 1; results appear on cycles 2..5 in order.
- Backpressure:
  - Hold OUT_READY=0 after 3 accepts -> third op stalls, IN_READY=0 once both stages full, OUTDATA stable.
  - Release -> results drain in order, none dropped or duplicated.
- Random: 2000 random ops with random IN_VALID/OUT_READY -> output sequence matches the reference model in order.
